// File: rtl/cla_pkg.sv
// cla_pkg: shared types and helpers for the pipelined carry-lookahead adder.
//   op_e      - operation select (wrap add, subtract, saturating add, per-lane saturating add)
//   sat_value - saturation pattern 0111..1 (neg=0) or 1000..0 (neg=1) of a given width,
//               returned right-aligned in a SAT_MAX_W-bit word (callers size-cast it)
package cla_pkg;

  typedef enum logic [1:0] {
    OP_ADD    = 2'd0,
    OP_SUB    = 2'd1,
    OP_ADDS   = 2'd2,
    OP_PADDSB = 2'd3
  } op_e;

  localparam int SAT_MAX_W = 64;

  function automatic logic [SAT_MAX_W-1:0] sat_value(input logic neg, input int width);
    logic [SAT_MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < SAT_MAX_W; i++) begin
      if (i < width) begin
        v[i] = (i == width - 1) ? neg : ~neg;
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/cla_lane.sv
// cla_lane: one LANE-bit lookahead group.
//   a, b   in   LANE  lane operands (b already inverted for subtract)
//   grp_g  out  1     group generate
//   grp_p  out  1     group propagate
//   sum0   out  LANE  lane sum assuming carry-in 0
//   sum1   out  LANE  lane sum assuming carry-in 1
module cla_lane
  import cla_pkg::*;
#(
  parameter int LANE = 4
) (
  input  logic [LANE-1:0] a,
  input  logic [LANE-1:0] b,
  output logic            grp_g,
  output logic            grp_p,
  output logic [LANE-1:0] sum0,
  output logic [LANE-1:0] sum1
);

  logic [LANE-1:0] bit_g;
  logic [LANE-1:0] bit_p;

  assign bit_g = a & b;
  // OR-form propagate is sufficient for carry production (G | P&c).
  assign bit_p = a | b;

  // G = g[n-1] | p[n-1]g[n-2] | ... | p[n-1]..p[1]g[0], folded from the LSB up.
  always_comb begin
    grp_g = 1'b0;
    for (int i = 0; i < LANE; i++) begin
      grp_g = bit_g[i] | (bit_p[i] & grp_g);
    end
  end

  assign grp_p = &bit_p;

  // Carry-select pair; stage 2 picks one once the lane carry is known.
  assign sum0 = a + b;
  assign sum1 = a + b + LANE'(1);

endmodule

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: two-stage pipelined carry-lookahead adder with valid/ready handshake.
// Stage 1 forms per-lane G/P and carry-select sums; stage 2 resolves lane carries,
// selects sums, saturates and computes flags. WIDTH must be a multiple of LANE.
//   clk, rst        clock, asynchronous active-high reset
//   in_valid/ready  input handshake; in_ready does not depend on in_valid
//   op              0 ADD, 1 SUB, 2 ADDS (full-width saturating), 3 PADDSB (per-lane saturating)
//   a, b, cin       operands (two's complement), carry-in (ADD only)
//   out_valid/ready output handshake; outputs hold while out_valid & !out_ready
//   sum, cout       result, carry out of MSB (ADD/SUB only)
//   flag_n/z/v      negative, zero, signed overflow (on post-saturation sum)
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LANE  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_v
);

  localparam int NL = WIDTH / LANE;

  // ---------------- stage 1: operand prep and lane groups ----------------
  op_e              op_in;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  assign op_in = op_e'(op);

  always_comb begin
    b_eff   = b;
    cin_eff = 1'b0;
    case (op_in)
      OP_ADD: cin_eff = cin;
      OP_SUB: begin
        b_eff   = ~b;
        cin_eff = 1'b1;
      end
      default: ;
    endcase
  end

  logic [NL-1:0]    lane_g;
  logic [NL-1:0]    lane_p;
  logic [WIDTH-1:0] lane_s0;
  logic [WIDTH-1:0] lane_s1;
  logic [NL-1:0]    lane_a_msb;
  logic [NL-1:0]    lane_b_msb;

  for (genvar i = 0; i < NL; i++) begin : g_lane
    cla_lane #(.LANE(LANE)) u_lane (
      .a     (a[i*LANE +: LANE]),
      .b     (b_eff[i*LANE +: LANE]),
      .grp_g (lane_g[i]),
      .grp_p (lane_p[i]),
      .sum0  (lane_s0[i*LANE +: LANE]),
      .sum1  (lane_s1[i*LANE +: LANE])
    );
    assign lane_a_msb[i] = a[i*LANE + LANE - 1];
    assign lane_b_msb[i] = b_eff[i*LANE + LANE - 1];
  end

  // ---------------- handshake ----------------
  logic s1_valid;
  logic s1_load;
  logic s2_load;

  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = !s1_valid || !out_valid || out_ready;

  // ---------------- stage 1 registers ----------------
  logic [NL-1:0]    s1_g;
  logic [NL-1:0]    s1_p;
  logic [WIDTH-1:0] s1_s0;
  logic [WIDTH-1:0] s1_s1;
  logic [NL-1:0]    s1_a_msb;
  logic [NL-1:0]    s1_b_msb;
  op_e              s1_op;
  logic             s1_cin;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_g     <= '0;
      s1_p     <= '0;
      s1_s0    <= '0;
      s1_s1    <= '0;
      s1_a_msb <= '0;
      s1_b_msb <= '0;
      s1_op    <= OP_ADD;
      s1_cin   <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_g     <= lane_g;
        s1_p     <= lane_p;
        s1_s0    <= lane_s0;
        s1_s1    <= lane_s1;
        s1_a_msb <= lane_a_msb;
        s1_b_msb <= lane_b_msb;
        s1_op    <= op_in;
        s1_cin   <= cin_eff;
      end
    end
  end

  // ---------------- stage 2: lookahead, select, saturate ----------------
  logic [NL:0]      c_la;
  logic [NL-1:0]    c_sel;
  logic [WIDTH-1:0] raw_sum;
  logic             raw_v;
  logic [WIDTH-1:0] fin_sum;
  logic             fin_v;
  logic             fin_cout;

  always_comb begin
    c_la    = '0;
    c_sel   = '0;
    raw_sum = '0;
    c_la[0] = s1_cin;
    for (int i = 0; i < NL; i++) begin
      c_la[i+1] = s1_g[i] | (s1_p[i] & c_la[i]);
    end
    // Packed-byte mode isolates lanes: only lane 0 sees the (zero) carry-in.
    for (int i = 0; i < NL; i++) begin
      c_sel[i] = (s1_op == OP_PADDSB && i != 0) ? 1'b0 : c_la[i];
    end
    for (int i = 0; i < NL; i++) begin
      raw_sum[i*LANE +: LANE] = c_sel[i] ? s1_s1[i*LANE +: LANE] : s1_s0[i*LANE +: LANE];
    end
    raw_v = (s1_a_msb[NL-1] == s1_b_msb[NL-1]) && (raw_sum[WIDTH-1] != s1_a_msb[NL-1]);

    fin_sum  = raw_sum;
    fin_v    = raw_v;
    fin_cout = 1'b0;
    case (s1_op)
      OP_ADD, OP_SUB: fin_cout = c_la[NL];
      OP_ADDS: begin
        // Overflow direction follows the (common) operand sign.
        if (raw_v) fin_sum = WIDTH'(sat_value(s1_a_msb[NL-1], WIDTH));
      end
      OP_PADDSB: begin
        fin_v = 1'b0;
        for (int i = 0; i < NL; i++) begin
          if (s1_a_msb[i] == s1_b_msb[i] && raw_sum[i*LANE + LANE - 1] != s1_a_msb[i]) begin
            fin_sum[i*LANE +: LANE] = LANE'(sat_value(s1_a_msb[i], LANE));
          end
        end
      end
      default: ;
    endcase
  end

  // ---------------- stage 2 / output registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      flag_n    <= 1'b0;
      flag_z    <= 1'b0;
      flag_v    <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        sum    <= fin_sum;
        cout   <= fin_cout;
        flag_n <= fin_sum[WIDTH-1];
        flag_z <= (fin_sum == '0);
        flag_v <= fin_v;
      end
    end
  end

endmodule

// File: tb/tb_cla_pipe_adder.sv
module tb_cla_pipe_adder;
  import cla_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic        in_valid, out_ready, cin;
  logic [1:0]  op;
  logic [31:0] a32, b32;

  logic        rdy8, ov8, co8, n8, z8, v8;
  logic [7:0]  sum8;
  logic        rdy16, ov16, co16, n16, z16, v16;
  logic [15:0] sum16;
  logic        rdy32, ov32, co32, n32, z32, v32;
  logic [31:0] sum32;

  cla_pipe_adder #(.WIDTH(16), .LANE(4)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy16), .op(op),
    .a(a32[15:0]), .b(b32[15:0]), .cin(cin), .out_valid(ov16), .out_ready(out_ready),
    .sum(sum16), .cout(co16), .flag_n(n16), .flag_z(z16), .flag_v(v16));

  cla_pipe_adder #(.WIDTH(8), .LANE(4)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy8), .op(op),
    .a(a32[7:0]), .b(b32[7:0]), .cin(cin), .out_valid(ov8), .out_ready(out_ready),
    .sum(sum8), .cout(co8), .flag_n(n8), .flag_z(z8), .flag_v(v8));

  cla_pipe_adder #(.WIDTH(32), .LANE(8)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32), .op(op),
    .a(a32), .b(b32), .cin(cin), .out_valid(ov32), .out_ready(out_ready),
    .sum(sum32), .cout(co32), .flag_n(n32), .flag_z(z32), .flag_v(v32));

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        n;
    logic        z;
    logic        v;
  } res_t;

  function automatic string fmt(res_t r);
    return $sformatf("sum=%h cout=%b n=%b z=%b v=%b", r.sum, r.cout, r.n, r.z, r.v);
  endfunction

  // Signed value of the low w bits of x.
  function automatic longint sx(longint x, int w);
    if (((x >> (w - 1)) & 1) != 0) return x - (longint'(1) << w);
    return x;
  endfunction

  // Behavioural reference: plain signed/unsigned arithmetic on w-bit values.
  function automatic res_t ref_model(int opi, logic [31:0] ai, logic [31:0] bi, logic ci,
                                     int w, int l);
    res_t   r;
    longint mask, ua, ub, sa, sb, s, t, mx, mn, acc, lmask, lmx, lmn, lt;
    r     = '0;
    mask  = (longint'(1) << w) - 1;
    ua    = longint'(ai) & mask;
    ub    = longint'(bi) & mask;
    sa    = sx(ua, w);
    sb    = sx(ub, w);
    mx    = (longint'(1) << (w - 1)) - 1;
    mn    = -mx - 1;
    acc   = 0;
    case (opi)
      0: begin
        s      = ua + ub + longint'(ci);
        acc    = s & mask;
        r.cout = ((s >> w) & 1) != 0;
        t      = sa + sb + longint'(ci);
        r.v    = (t > mx) || (t < mn);
      end
      1: begin
        s      = ua + ((~ub) & mask) + 1;
        acc    = s & mask;
        r.cout = ((s >> w) & 1) != 0;
        t      = sa - sb;
        r.v    = (t > mx) || (t < mn);
      end
      2: begin
        t   = sa + sb;
        r.v = (t > mx) || (t < mn);
        if (t > mx) t = mx;
        if (t < mn) t = mn;
        acc = t & mask;
      end
      default: begin
        lmask = (longint'(1) << l) - 1;
        lmx   = (longint'(1) << (l - 1)) - 1;
        lmn   = -lmx - 1;
        for (int k = 0; k < w / l; k++) begin
          lt = sx((ua >> (k * l)) & lmask, l) + sx((ub >> (k * l)) & lmask, l);
          if (lt > lmx) lt = lmx;
          if (lt < lmn) lt = lmn;
          acc = acc | ((lt & lmask) << (k * l));
        end
      end
    endcase
    r.sum = 32'(acc);
    r.n   = ((acc >> (w - 1)) & 1) != 0;
    r.z   = (acc == 0);
    return r;
  endfunction

  // Drives one transaction into an empty pipeline with out_ready=1 and waits
  // (bounded) for the result. lat counts negedges after the acceptance edge; 0 = timeout.
  task automatic run_one(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic c, output res_t got, output int lat);
    @(posedge clk); #1;
    op = o; a32 = x; b32 = y; cin = c; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (ov16) begin
        lat = k;
        break;
      end
    end
    got = {32'(sum16), co16, n16, z16, v16};
  endtask

  task automatic test_reset();
    res_t got;
    in_valid = 1'b0; out_ready = 1'b0; op = 2'd0; a32 = '0; b32 = '0; cin = 1'b0;
    #2 rst = 1'b1;
    #1;
    got = {32'(sum16), co16, n16, z16, v16};
    total++;
    if (got !== res_t'(0)) begin
      bad++; $display("FAIL reset_outputs: got %s want all zero", fmt(got));
    end
    total++;
    if (ov16 !== 1'b0 || rdy16 !== 1'b1) begin
      bad++; $display("FAIL reset_handshake: out_valid=%b in_ready=%b want 0/1", ov16, rdy16);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    total++;
    if (ov16 !== 1'b0 || rdy16 !== 1'b1) begin
      bad++; $display("FAIL reset_idle: out_valid=%b in_ready=%b want 0/1", ov16, rdy16);
    end
  endtask

  task automatic test_add_overflow();
    res_t got, exp;
    int   lat;
    run_one(OP_ADD, 32'h7FFF, 32'h0001, 1'b0, got, lat);
    total++;
    if (lat != 2) begin
      bad++; $display("FAIL add_latency: got %0d want 2", lat);
    end
    exp = {32'h0000_8000, 1'b0, 1'b1, 1'b0, 1'b1};
    total++;
    if (got !== exp) begin
      bad++; $display("FAIL add_7fff_plus_1: got %s want %s", fmt(got), fmt(exp));
    end
    run_one(OP_ADDS, 32'h7FFF, 32'h0001, 1'b0, got, lat);
    exp = {32'h0000_7FFF, 1'b0, 1'b0, 1'b0, 1'b1};
    total++;
    if (lat != 2 || got !== exp) begin
      bad++; $display("FAIL adds_7fff_plus_1: lat=%0d got %s want lat=2 %s", lat, fmt(got), fmt(exp));
    end
  endtask

  task automatic test_sub();
    res_t got, exp;
    int   lat;
    run_one(OP_SUB, 32'h0005, 32'h0007, 1'b0, got, lat);
    exp = {32'h0000_FFFE, 1'b0, 1'b1, 1'b0, 1'b0};
    total++;
    if (lat != 2 || got !== exp) begin
      bad++; $display("FAIL sub_5_minus_7: lat=%0d got %s want lat=2 %s", lat, fmt(got), fmt(exp));
    end
    run_one(OP_SUB, 32'h1234, 32'h1234, 1'b1, got, lat);
    exp = {32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
    total++;
    if (lat != 2 || got !== exp) begin
      bad++; $display("FAIL sub_equal: lat=%0d got %s want lat=2 %s", lat, fmt(got), fmt(exp));
    end
  endtask

  task automatic test_paddsb();
    res_t got, exp;
    int   lat;
    // Lanes (MSB..LSB): 7+1=+8 -> 7, -8+1=-7 -> 9, 7-8=-1 -> F, -8-8=-16 -> 8.
    run_one(OP_PADDSB, 32'h7878, 32'h1188, 1'b1, got, lat);
    exp = {32'h0000_79F8, 1'b0, 1'b0, 1'b0, 1'b0};
    total++;
    if (lat != 2 || got !== exp) begin
      bad++; $display("FAIL paddsb_mixed: lat=%0d got %s want lat=2 %s", lat, fmt(got), fmt(exp));
    end
    // Every lane saturates: 7+1 -> 7, -8-8 -> 8 alternating.
    run_one(OP_PADDSB, 32'h7878, 32'h1818, 1'b0, got, lat);
    exp = {32'h0000_7878, 1'b0, 1'b0, 1'b0, 1'b0};
    total++;
    if (lat != 2 || got !== exp) begin
      bad++; $display("FAIL paddsb_all_sat: lat=%0d got %s want lat=2 %s", lat, fmt(got), fmt(exp));
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] want [3];
    logic [15:0] held;
    logic        was_held, acc;
    int          got_n;
    want[0] = 16'd2; want[1] = 16'd4; want[2] = 16'd6;
    got_n = 0; was_held = 1'b0; held = '0;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; op = OP_ADD; cin = 1'b0; a32 = 32'd1; b32 = 32'd1;
    @(negedge clk);
    total++;
    if (rdy16 !== 1'b1) begin
      bad++; $display("FAIL bp_ready_first: in_ready=%b want 1", rdy16);
    end
    @(posedge clk); #1;
    a32 = 32'd2; b32 = 32'd2;
    @(negedge clk);
    total++;
    if (rdy16 !== 1'b1) begin
      bad++; $display("FAIL bp_ready_second: in_ready=%b want 1", rdy16);
    end
    @(posedge clk); #1;
    a32 = 32'd3; b32 = 32'd3;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (rdy16 !== 1'b0 || ov16 !== 1'b1 || sum16 !== 16'd2) begin
        bad++;
        $display("FAIL bp_full: in_ready=%b out_valid=%b sum=%h want 0/1/0002", rdy16, ov16, sum16);
      end
      @(posedge clk); #1;
    end
    for (int k = 0; k < 20 && got_n < 3; k++) begin
      out_ready = (k == 1 || k == 2) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (was_held) begin
        total++;
        if (ov16 !== 1'b1 || sum16 !== held) begin
          bad++; $display("FAIL bp_hold: out_valid=%b sum=%h want 1/%h", ov16, sum16, held);
        end
      end
      if (ov16 && out_ready) begin
        total++;
        if (sum16 !== want[got_n]) begin
          bad++; $display("FAIL bp_order: result %0d sum=%h want %h", got_n, sum16, want[got_n]);
        end
        got_n++;
      end
      was_held = ov16 && !out_ready;
      held     = sum16;
      acc      = in_valid && rdy16;
      @(posedge clk); #1;
      if (acc) in_valid = 1'b0;
    end
    total++;
    if (got_n != 3) begin
      bad++; $display("FAIL bp_count: got %0d results want 3", got_n);
    end
    @(negedge clk);
    total++;
    if (ov16 !== 1'b0) begin
      bad++; $display("FAIL bp_no_dup: out_valid=%b want 0", ov16);
    end
  endtask

  task automatic test_reset_midflight();
    res_t got, exp;
    int   lat;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; op = OP_ADD; cin = 1'b0; a32 = 32'd10; b32 = 32'd20;
    @(posedge clk); #1;
    a32 = 32'd30; b32 = 32'd40;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++;
    if (ov16 !== 1'b1 || sum16 !== 16'd30) begin
      bad++; $display("FAIL mf_inflight: out_valid=%b sum=%h want 1/001e", ov16, sum16);
    end
    #2 rst = 1'b1;
    #1;
    got = {32'(sum16), co16, n16, z16, v16};
    total++;
    if (ov16 !== 1'b0 || got !== res_t'(0) || rdy16 !== 1'b1) begin
      bad++;
      $display("FAIL mf_async_reset: out_valid=%b in_ready=%b %s want 0/1 all zero", ov16, rdy16, fmt(got));
    end
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (ov16 !== 1'b0) begin
        bad++; $display("FAIL mf_discard: cycle %0d out_valid=%b want 0", k, ov16);
      end
    end
    run_one(OP_ADD, 32'hFFFF, 32'h0001, 1'b0, got, lat);
    exp = {32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
    total++;
    if (lat != 2 || got !== exp) begin
      bad++; $display("FAIL mf_wrap_add: lat=%0d got %s want lat=2 %s", lat, fmt(got), fmt(exp));
    end
  endtask

  task automatic test_random();
    res_t q8[$], q16[$], q32[$];
    res_t exp, act;
    int   accepted;
    logic acc;
    localparam int N = 4000;
    accepted = 0; acc = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int cyc = 0; cyc < 30000; cyc++) begin
      if (accepted >= N && q8.size() == 0 && q16.size() == 0 && q32.size() == 0) break;
      if (accepted >= N) begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end else begin
        if (!in_valid || acc) begin
          in_valid = (cyc < 1000) ? 1'b1 : ($urandom_range(0, 3) != 0);
          a32      = $urandom;
          b32      = $urandom;
          op       = 2'($urandom_range(0, 3));
          cin      = 1'($urandom_range(0, 1));
        end
        out_ready = (cyc < 1000) ? 1'b1 : ($urandom_range(0, 2) != 0);
      end
      @(negedge clk);
      if (rdy8 !== rdy16 || rdy32 !== rdy16) begin
        total++; bad++;
        $display("FAIL rand_ready_agree: in_ready 8/16/32 = %b/%b/%b", rdy8, rdy16, rdy32);
      end
      if (ov16 && out_ready) begin
        total++;
        act = {32'(sum16), co16, n16, z16, v16};
        if (q16.size() == 0) begin
          bad++; $display("FAIL rand_w16_extra: got %s with nothing outstanding", fmt(act));
        end else begin
          exp = q16.pop_front();
          if (act !== exp) begin
            bad++; $display("FAIL rand_w16: got %s want %s", fmt(act), fmt(exp));
          end
        end
      end
      if (ov8 && out_ready) begin
        total++;
        act = {32'(sum8), co8, n8, z8, v8};
        if (q8.size() == 0) begin
          bad++; $display("FAIL rand_w8_extra: got %s with nothing outstanding", fmt(act));
        end else begin
          exp = q8.pop_front();
          if (act !== exp) begin
            bad++; $display("FAIL rand_w8: got %s want %s", fmt(act), fmt(exp));
          end
        end
      end
      if (ov32 && out_ready) begin
        total++;
        act = {sum32, co32, n32, z32, v32};
        if (q32.size() == 0) begin
          bad++; $display("FAIL rand_w32_extra: got %s with nothing outstanding", fmt(act));
        end else begin
          exp = q32.pop_front();
          if (act !== exp) begin
            bad++; $display("FAIL rand_w32: got %s want %s", fmt(act), fmt(exp));
          end
        end
      end
      acc = in_valid && rdy16;
      if (acc) begin
        q16.push_back(ref_model(int'(op), a32, b32, cin, 16, 4));
        q8.push_back(ref_model(int'(op), a32, b32, cin, 8, 4));
        q32.push_back(ref_model(int'(op), a32, b32, cin, 32, 8));
        accepted++;
      end
      @(posedge clk); #1;
    end
    total++;
    if (accepted != N || q8.size() != 0 || q16.size() != 0 || q32.size() != 0) begin
      bad++;
      $display("FAIL rand_complete: accepted=%0d left 8/16/32=%0d/%0d/%0d want %0d and 0",
               accepted, q8.size(), q16.size(), q32.size(), N);
    end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_sub();
    test_paddsb();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
